mode_controller: RTL and testbench
==================================

# mode_controller

Central user-interface sequencer for the alarm clock. It takes the five debounced push-button levels and performs per-button rising-edge detection internally. It steps a five-state mode machine (run clock, set time hours/minutes, set alarm hours/minutes) and issues single-cycle adjust, alarm-toggle and silence commands to the timekeeping and alarm datapaths. It sits between the button debouncers and the time/alarm counters, and also drives the display's blink and hold controls.

## Interface
Parameters:
- TIMEOUT_S, 30: idle seconds in any set mode before automatic return to CLOCK. Legal range 1–255.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- tick_1hz  in  1  one-cycle strobe, once per second.
- btn_c, btn_u, btn_d, btn_l, btn_r  in  1 each  debounced, synchronous button levels (1 = pressed).
- alarm_ringing  in  1  level from the alarm comparator.
- mode  out  3  0 CLOCK, 1 SET_HR, 2 SET_MIN, 3 ALM_HR, 4 ALM_MIN.
- adj_up, adj_dn  out  1 each  one-cycle increment/decrement command for the selected field.
- adj_field  out  1  1 = hours, 0 = minutes. Valid whenever adj_up or adj_dn is high.
- adj_target  out  1  1 = alarm registers, 0 = time registers.
- alarm_en  out  1  alarm arm flag.
- silence  out  1  one-cycle pulse that stops the alarm.
- hold_time  out  1  1 in SET_HR/SET_MIN; pauses seconds counting.
- blink  out  1  display blink phase for the selected field.

## Operation
- Edge detect: one prev register per button; edge_x = btn_x & ~prev_x. prev registers reset to 1, so a button held through reset release produces no edge.
- One action per cycle. Priority among simultaneous edges:
  1. silence (btn_c edge while alarm_ringing=1)
  2. btn_l
  3. btn_c
  4. btn_u
  5. btn_d
  6. btn_r
- Lower-priority edges in the same cycle are discarded, not queued.
- silence: pulse silence. Mode is unchanged.
- btn_c: CLOCK→SET_HR→SET_MIN→ALM_HR→ALM_MIN→CLOCK.
- btn_l: in any set mode, go to CLOCK. In CLOCK it is ignored.
- btn_u / btn_d: in set modes, pulse adj_up / adj_dn. In CLOCK they are ignored and do not clear the idle counter.
- btn_r: in CLOCK, toggle alarm_en. In set modes it is ignored.
- adj_field = 1 in SET_HR/ALM_HR. adj_target = 1 in ALM_HR/ALM_MIN. Both are registered decodes of mode; 0 in CLOCK.
- Idle counter, width 8:
  - Clears on any accepted action and on every mode change.
  - Increments on tick_1hz while in a set mode.
  - When a tick arrives with count = TIMEOUT_S−1, mode goes to CLOCK.
  - If an accepted button action and a tick fall in the same cycle, the action wins and the counter clears.
- blink: forced to 1 on entry to any set mode; toggles on each tick_1hz while in a set mode; 0 in CLOCK.
- hold_time: 1 exactly when mode is SET_HR or SET_MIN.

## Timing
- All outputs are registered.
- Reset values: mode = 0, adj_up = adj_dn = adj_field = adj_target = 0, alarm_en = 0, silence = 0, hold_time = 0, blink = 0. Idle counter = 0; prev_* = 1.
- Latency: button sampled 1 at edge k (after being sampled 0 at edge k−1) → output change or pulse is visible after edge k+1. It is high for exactly one cycle for pulses.
- Holding a button produces exactly one action. Release followed by re-press produces another.
- Timeout: mode reads 0 in the cycle after the qualifying tick_1hz cycle.
- Reset mid-operation: all state returns to reset values immediately (asynchronous), independent of clk. Any in-flight pulse is cut.
- Reset deassertion is assumed synchronised upstream. The first active edge after deassertion performs a normal update.

## Test plan
- Reset with btn_c held, release rst, keep btn_c high 10 cycles → mode stays 0, no pulses. Release btn_c and press again → mode = 1 two edges later.
- Press btn_c four times from CLOCK → mode sequence 1,2,3,4. A fifth press → mode = 0. hold_time = 1 only while mode is 1 or 2.
- In ALM_HR, press btn_u → a single one-cycle adj_up with adj_field = 1 and adj_target = 1. Press btn_d in SET_MIN → adj_dn with adj_field = 0 and adj_target = 0.
- TIMEOUT_S = 3, enter SET_HR, apply 3 ticks with no buttons → mode = 0 after the third tick. Repeat with a btn_u edge in the cycle of the second tick → counter clears, and mode stays 1 until 3 further ticks.
- alarm_ringing = 1 in CLOCK, btn_c and btn_r edges in the same cycle → one silence pulse, mode = 0, alarm_en unchanged.
- In SET_MIN, btn_l and btn_c edges in the same cycle → mode = 0. Assert rst mid-sequence in ALM_MIN with blink = 1 → all outputs are 0 immediately.

Source files
------------

// File: rtl/mode_controller.sv
// mode_controller: button-driven user-interface sequencer for the alarm clock.
// Detects button rising edges, steps the five-state mode machine, issues
// one-cycle adjust / silence commands and drives display blink and hold.
module mode_controller #(
  parameter int unsigned TIMEOUT_S = 30
) (
  input  logic       clk,
  input  logic       rst,            // active-low, asynchronous
  input  logic       tick_1hz,
  input  logic       btn_c,
  input  logic       btn_u,
  input  logic       btn_d,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       alarm_ringing,
  output logic [2:0] mode,
  output logic       adj_up,
  output logic       adj_dn,
  output logic       adj_field,
  output logic       adj_target,
  output logic       alarm_en,
  output logic       silence,
  output logic       hold_time,
  output logic       blink
);

  typedef enum logic [2:0] {
    M_CLOCK   = 3'd0,
    M_SET_HR  = 3'd1,
    M_SET_MIN = 3'd2,
    M_ALM_HR  = 3'd3,
    M_ALM_MIN = 3'd4
  } mode_t;

  localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT_S - 1);

  // Button bit order used throughout: {c, u, d, l, r}
  localparam int B_C = 4;
  localparam int B_U = 3;
  localparam int B_D = 2;
  localparam int B_L = 1;
  localparam int B_R = 0;

  mode_t      mode_q, mode_d;
  logic [4:0] samp_q, samp_d;   // buttons sampled this edge
  logic [4:0] prev_q, prev_d;   // buttons sampled one edge earlier
  logic [7:0] idle_q, idle_d;
  logic       adj_up_q, adj_up_d;
  logic       adj_dn_q, adj_dn_d;
  logic       adj_field_q, adj_field_d;
  logic       adj_target_q, adj_target_d;
  logic       alarm_en_q, alarm_en_d;
  logic       silence_q, silence_d;
  logic       hold_time_q, hold_time_d;
  logic       blink_q, blink_d;

  logic [4:0] edges;
  logic       in_set;
  logic       action;

  // Next-state logic: pick at most one action per cycle, then idle timer and display decodes
  always_comb begin
    samp_d       = {btn_c, btn_u, btn_d, btn_l, btn_r};
    prev_d       = samp_q;
    mode_d       = mode_q;
    idle_d       = idle_q;
    adj_up_d     = 1'b0;
    adj_dn_d     = 1'b0;
    silence_d    = 1'b0;
    alarm_en_d   = alarm_en_q;
    blink_d      = blink_q;
    action       = 1'b0;
    edges        = samp_q & ~prev_q;
    in_set       = (mode_q != M_CLOCK);

    // Priority chain; edges that are meaningless in the current mode fall through
    if (edges[B_C] && alarm_ringing) begin
      silence_d = 1'b1;
      action    = 1'b1;
    end else if (edges[B_L] && in_set) begin
      mode_d = M_CLOCK;
      action = 1'b1;
    end else if (edges[B_C]) begin
      action = 1'b1;
      case (mode_q)
        M_CLOCK:   mode_d = M_SET_HR;
        M_SET_HR:  mode_d = M_SET_MIN;
        M_SET_MIN: mode_d = M_ALM_HR;
        M_ALM_HR:  mode_d = M_ALM_MIN;
        default:   mode_d = M_CLOCK;
      endcase
    end else if (edges[B_U] && in_set) begin
      adj_up_d = 1'b1;
      action   = 1'b1;
    end else if (edges[B_D] && in_set) begin
      adj_dn_d = 1'b1;
      action   = 1'b1;
    end else if (edges[B_R] && !in_set) begin
      alarm_en_d = ~alarm_en_q;
      action     = 1'b1;
    end

    // Idle timer: an accepted action beats a coincident tick
    if (action) begin
      idle_d = 8'd0;
    end else if (tick_1hz && in_set) begin
      if (idle_q == IDLE_LAST) begin
        mode_d = M_CLOCK;
        idle_d = 8'd0;
      end else begin
        idle_d = idle_q + 8'd1;
      end
    end

    // Blink restarts in the "on" phase whenever a set mode is entered
    if (mode_d == M_CLOCK) begin
      blink_d = 1'b0;
    end else if (mode_d != mode_q) begin
      blink_d = 1'b1;
    end else if (tick_1hz) begin
      blink_d = ~blink_q;
    end

    // Decodes taken from the next mode so they line up with the mode output
    adj_field_d  = (mode_d == M_SET_HR) || (mode_d == M_ALM_HR);
    adj_target_d = (mode_d == M_ALM_HR) || (mode_d == M_ALM_MIN);
    hold_time_d  = (mode_d == M_SET_HR) || (mode_d == M_SET_MIN);
  end

  // State registers; button history resets to "pressed" so a held button gives no edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q       <= M_CLOCK;
      samp_q       <= 5'b11111;
      prev_q       <= 5'b11111;
      idle_q       <= 8'd0;
      adj_up_q     <= 1'b0;
      adj_dn_q     <= 1'b0;
      adj_field_q  <= 1'b0;
      adj_target_q <= 1'b0;
      alarm_en_q   <= 1'b0;
      silence_q    <= 1'b0;
      hold_time_q  <= 1'b0;
      blink_q      <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      samp_q       <= samp_d;
      prev_q       <= prev_d;
      idle_q       <= idle_d;
      adj_up_q     <= adj_up_d;
      adj_dn_q     <= adj_dn_d;
      adj_field_q  <= adj_field_d;
      adj_target_q <= adj_target_d;
      alarm_en_q   <= alarm_en_d;
      silence_q    <= silence_d;
      hold_time_q  <= hold_time_d;
      blink_q      <= blink_d;
    end
  end

  assign mode       = mode_q;
  assign adj_up     = adj_up_q;
  assign adj_dn     = adj_dn_q;
  assign adj_field  = adj_field_q;
  assign adj_target = adj_target_q;
  assign alarm_en   = alarm_en_q;
  assign silence    = silence_q;
  assign hold_time  = hold_time_q;
  assign blink      = blink_q;

endmodule

// File: tb/tb_mode_controller.sv
// Testbench for mode_controller: directed scenarios plus randomized traffic,
// all checked against a behavioural model of the user-interface rules.
module tb_mode_controller;

  localparam int T = 3;

  localparam logic [4:0] BN = 5'b00000;
  localparam logic [4:0] BC = 5'b10000;
  localparam logic [4:0] BU = 5'b01000;
  localparam logic [4:0] BD = 5'b00100;
  localparam logic [4:0] BL = 5'b00010;
  localparam logic [4:0] BR = 5'b00001;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_1hz;
  logic       btn_c, btn_u, btn_d, btn_l, btn_r;
  logic       alarm_ringing;
  logic [2:0] mode;
  logic       adj_up, adj_dn, adj_field, adj_target;
  logic       alarm_en, silence, hold_time, blink;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  int         m_mode;
  int         m_idle;
  bit         m_up, m_dn, m_field, m_tgt, m_ae, m_sil, m_hold, m_blink;
  logic [4:0] s1, s2;   // last two sampled button vectors

  mode_controller #(.TIMEOUT_S(T)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
    .btn_c(btn_c), .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r),
    .alarm_ringing(alarm_ringing),
    .mode(mode), .adj_up(adj_up), .adj_dn(adj_dn), .adj_field(adj_field),
    .adj_target(adj_target), .alarm_en(alarm_en), .silence(silence),
    .hold_time(hold_time), .blink(blink)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] got_v();
    return {mode, adj_up, adj_dn, adj_field, adj_target, alarm_en, silence, hold_time, blink};
  endfunction

  function automatic logic [10:0] exp_v();
    return {3'(m_mode), m_up, m_dn, m_field, m_tgt, m_ae, m_sil, m_hold, m_blink};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_idle = 0;
    m_up = 0; m_dn = 0; m_field = 0; m_tgt = 0; m_ae = 0; m_sil = 0; m_hold = 0; m_blink = 0;
    s1 = 5'b11111; s2 = 5'b11111;
  endtask

  // One clock: drive inputs at negedge, advance model, sample 1 time unit after posedge
  task automatic cycle(input logic [4:0] b, input logic tk, input logic rg);
    logic [4:0] e;
    int  nm;
    bit  act, ins;
    @(negedge clk);
    {btn_c, btn_u, btn_d, btn_l, btn_r} = b;
    tick_1hz = tk;
    alarm_ringing = rg;
    e   = s1 & ~s2;
    nm  = m_mode;
    act = 1'b0;
    ins = (m_mode != 0);
    m_up = 0; m_dn = 0; m_sil = 0;
    if (e[4] && rg)         begin m_sil = 1; act = 1; end
    else if (e[1] && ins)   begin nm = 0; act = 1; end
    else if (e[4])          begin nm = (m_mode + 1) % 5; act = 1; end
    else if (e[3] && ins)   begin m_up = 1; act = 1; end
    else if (e[2] && ins)   begin m_dn = 1; act = 1; end
    else if (e[0] && !ins)  begin m_ae = !m_ae; act = 1; end
    if (act) m_idle = 0;
    else if (tk && ins) begin
      if (m_idle == T - 1) begin nm = 0; m_idle = 0; end
      else m_idle++;
    end
    if (nm == 0) m_blink = 0;
    else if (nm != m_mode) m_blink = 1;
    else if (tk) m_blink = !m_blink;
    m_mode  = nm;
    m_field = (nm == 1 || nm == 3);
    m_tgt   = (nm >= 3);
    m_hold  = (nm == 1 || nm == 2);
    s2 = s1;
    s1 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    {btn_c, btn_u, btn_d, btn_l, btn_r} = BC;
    tick_1hz = 0; alarm_ringing = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (got_v() !== 11'd0) begin
      n_err++; $display("FAIL reset_state: got %b want %b", got_v(), 11'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle(BC, 0, 0);
      n_vec++;
      if (got_v() !== exp_v() || mode !== 3'd0 || adj_up !== 1'b0 || silence !== 1'b0) begin
        n_err++; $display("FAIL reset_held_c[%0d]: got %b want %b", i, got_v(), exp_v());
      end
    end
    cycle(BN, 0, 0);
    cycle(BC, 0, 0);
    n_vec++;
    if (mode !== 3'd0) begin
      n_err++; $display("FAIL repress_one_edge: mode got %0d want 0", mode);
    end
    cycle(BC, 0, 0);
    n_vec++;
    if (got_v() !== exp_v() || mode !== 3'd1) begin
      n_err++; $display("FAIL repress_two_edges: got %b want %b (mode 1)", got_v(), exp_v());
    end
  endtask

  task automatic test_mode_cycle();
    cycle(BL, 0, 0); cycle(BN, 0, 0);
    n_vec++;
    if (got_v() !== exp_v() || mode !== 3'd0) begin
      n_err++; $display("FAIL left_to_clock: got %b want %b", got_v(), exp_v());
    end
    for (int k = 1; k <= 5; k++) begin
      cycle(BC, 0, 0);
      cycle(BN, 0, 0);
      n_vec++;
      if (got_v() !== exp_v() || mode !== 3'(k % 5)
          || hold_time !== ((k % 5 == 1) || (k % 5 == 2))) begin
        n_err++; $display("FAIL mode_step[%0d]: got %b want %b (mode %0d)", k, got_v(), exp_v(), k % 5);
      end
    end
  endtask

  task automatic test_adjust();
    for (int k = 0; k < 3; k++) begin cycle(BC, 0, 0); cycle(BN, 0, 0); end
    cycle(BU, 0, 0);
    cycle(BU, 0, 0);
    n_vec++;
    if (got_v() !== exp_v() || {adj_up, adj_dn, adj_field, adj_target} !== 4'b1011 || mode !== 3'd3) begin
      n_err++; $display("FAIL alm_hr_up: got %b want %b", got_v(), exp_v());
    end
    cycle(BU, 0, 0);
    n_vec++;
    if (got_v() !== exp_v() || adj_up !== 1'b0) begin
      n_err++; $display("FAIL alm_hr_up_single: got %b want %b", got_v(), exp_v());
    end
    cycle(BL, 0, 0); cycle(BC, 0, 0); cycle(BN, 0, 0); cycle(BC, 0, 0); cycle(BN, 0, 0);
    cycle(BD, 0, 0);
    cycle(BN, 0, 0);
    n_vec++;
    if (got_v() !== exp_v() || {adj_up, adj_dn, adj_field, adj_target} !== 4'b0100 || mode !== 3'd2) begin
      n_err++; $display("FAIL set_min_dn: got %b want %b", got_v(), exp_v());
    end
  endtask

  task automatic test_timeout();
    cycle(BL, 0, 0); cycle(BC, 0, 0); cycle(BN, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      cycle(BN, 1, 0);
      n_vec++;
      if (got_v() !== exp_v() || mode !== ((k == 3) ? 3'd0 : 3'd1)) begin
        n_err++; $display("FAIL timeout_tick[%0d]: got %b want %b", k, got_v(), exp_v());
      end
      cycle(BN, 0, 0);
    end
    cycle(BC, 0, 0); cycle(BN, 0, 0);
    cycle(BN, 1, 0);
    cycle(BU, 0, 0);
    cycle(BN, 1, 0);
    n_vec++;
    if (got_v() !== exp_v() || mode !== 3'd1 || adj_up !== 1'b1) begin
      n_err++; $display("FAIL tick_with_action: got %b want %b", got_v(), exp_v());
    end
    for (int k = 1; k <= 3; k++) begin
      cycle(BN, 1, 0);
      n_vec++;
      if (got_v() !== exp_v() || mode !== ((k == 3) ? 3'd0 : 3'd1)) begin
        n_err++; $display("FAIL timeout_after_clear[%0d]: got %b want %b", k, got_v(), exp_v());
      end
    end
  endtask

  task automatic test_silence();
    cycle(BR, 0, 0); cycle(BN, 0, 0);
    n_vec++;
    if (got_v() !== exp_v() || alarm_en !== 1'b1) begin
      n_err++; $display("FAIL arm_toggle: got %b want %b", got_v(), exp_v());
    end
    cycle(BC | BR, 0, 1);
    cycle(BN, 0, 1);
    n_vec++;
    if (got_v() !== exp_v() || silence !== 1'b1 || mode !== 3'd0 || alarm_en !== 1'b1) begin
      n_err++; $display("FAIL silence_priority: got %b want %b", got_v(), exp_v());
    end
    cycle(BN, 0, 1);
    n_vec++;
    if (got_v() !== exp_v() || silence !== 1'b0) begin
      n_err++; $display("FAIL silence_single: got %b want %b", got_v(), exp_v());
    end
  endtask

  task automatic test_left_beats_center();
    cycle(BC, 0, 0); cycle(BN, 0, 0); cycle(BC, 0, 0); cycle(BN, 0, 0);
    cycle(BL | BC, 0, 0);
    cycle(BN, 0, 0);
    n_vec++;
    if (got_v() !== exp_v() || mode !== 3'd0) begin
      n_err++; $display("FAIL left_over_center: got %b want %b", got_v(), exp_v());
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 4; k++) begin cycle(BC, 0, 0); cycle(BN, 0, 0); end
    n_vec++;
    if (got_v() !== exp_v() || mode !== 3'd4 || blink !== 1'b1) begin
      n_err++; $display("FAIL enter_alm_min: got %b want %b", got_v(), exp_v());
    end
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if (got_v() !== 11'd0) begin
      n_err++; $display("FAIL async_reset: got %b want %b", got_v(), 11'd0);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cycle(BN, 0, 0);
    n_vec++;
    if (got_v() !== exp_v()) begin
      n_err++; $display("FAIL after_reset: got %b want %b", got_v(), exp_v());
    end
  endtask

  task automatic test_random();
    logic [4:0] b;
    logic       tk, rg;
    b = BN;
    for (int i = 0; i < 600; i++) begin
      for (int j = 0; j < 5; j++)
        if ($urandom_range(5) == 0) b[j] = ~b[j];
      tk = ($urandom_range(3) == 0);
      rg = ($urandom_range(2) == 0);
      cycle(b, tk, rg);
      n_vec++;
      if (got_v() !== exp_v()) begin
        n_err++; $display("FAIL random[%0d]: got %b want %b", i, got_v(), exp_v());
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode_cycle();
    test_adjust();
    test_timeout();
    test_silence();
    test_left_beats_center();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
